// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request side and result/flags response side of alu_seq.
// master drives requests and consumes results; slave is the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A_In;
  logic [WIDTH-1:0] B_In;
  logic             Carry_In;
  logic [3:0]       Opcode;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             Carry_Out;
  logic             Zero;
  logic             Negative;
  logic             Overflow;
  logic             Error;

  modport master (
    output In_Valid, A_In, B_In, Carry_In, Opcode, Out_Ready,
    input  In_Ready, Out_Valid, ALU_Out, Carry_Out, Zero, Negative, Overflow, Error
  );

  modport slave (
    input  In_Valid, A_In, B_In, Carry_In, Opcode, Out_Ready,
    output In_Ready, Out_Valid, ALU_Out, Carry_Out, Zero, Negative, Overflow, Error
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready on both sides and status flags.
// Define ALU_SEQ_SHIFT_EN to add multi-cycle SHL/SHR/ASR/ROL (one bit per cycle).
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic       i_clk,
  input logic       i_rst,
  alu_seq_if.slave  bus
);

  logic             w_accept;
  logic             w_in_ready;
  logic             w_is_shift;
  logic             w_done;
  logic [WIDTH-1:0] w_sh_res;
  logic             w_sh_c;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_e;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_c;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic             r_e;

  assign w_accept  = bus.In_Valid && w_in_ready;
  // SUB is A + ~B + Carry_In, so overflow is judged against the inverted operand.
  assign w_b_eff   = (bus.Opcode == 4'd1) ? ~bus.B_In : bus.B_In;
  assign w_sum     = {1'b0, bus.A_In} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, bus.Carry_In};
  assign w_add_ovf = (bus.A_In[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != bus.A_In[WIDTH-1]);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_e   = 1'b0;
    case (bus.Opcode)
      4'd0, 4'd1: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_ovf;
      end
      4'd2:    w_res = ~bus.A_In;
      4'd3:    w_res = bus.A_In | bus.B_In;
      4'd4:    w_res = bus.A_In & bus.B_In;
      4'd5:    w_res = ~bus.A_In & bus.B_In;
      4'd6:    w_res = bus.A_In ^ bus.B_In;
      4'd7:    w_res = ~(bus.A_In ^ bus.B_In);
      default: w_e   = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_SHIFT_EN
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic           r_state;
  logic [SHW-1:0] r_cnt;
  logic [WIDTH-1:0] r_work;
  logic           r_shc;
  logic [1:0]     r_shop;

  assign w_is_shift = (bus.Opcode[3:2] == 2'b10);
  assign w_done     = (r_state == ST_SHIFT) && (r_cnt == '0);
  assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.Out_Ready);
  assign w_sh_res   = r_work;
  assign w_sh_c     = r_shc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_shc   <= 1'b0;
      r_shop  <= 2'd0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept && w_is_shift) begin
        r_state <= ST_SHIFT;
        r_cnt   <= bus.B_In[SHW-1:0];
        r_work  <= bus.A_In;
        r_shc   <= 1'b0;
        r_shop  <= bus.Opcode[1:0];
      end
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - SHW'(1);
      case (r_shop)
        2'd0: begin
          r_work <= {r_work[WIDTH-2:0], 1'b0};
          r_shc  <= r_work[WIDTH-1];
        end
        2'd1: begin
          r_work <= {1'b0, r_work[WIDTH-1:1]};
          r_shc  <= r_work[0];
        end
        2'd2: begin
          r_work <= {r_work[WIDTH-1], r_work[WIDTH-1:1]};
          r_shc  <= r_work[0];
        end
        default: begin
          r_work <= {r_work[WIDTH-2:0], r_work[WIDTH-1]};
          r_shc  <= r_work[WIDTH-1];
        end
      endcase
    end else begin
      r_state <= ST_IDLE;
    end
  end
`else
  assign w_is_shift = 1'b0;
  assign w_done     = 1'b0;
  assign w_in_ready = !r_out_valid || bus.Out_Ready;
  assign w_sh_res   = '0;
  assign w_sh_c     = 1'b0;
`endif

  // Acceptance implies the output slot is free or draining, so a load never overwrites live data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_e         <= 1'b0;
    end else if (w_accept && !w_is_shift) begin
      r_out_valid <= 1'b1;
      r_out       <= w_res;
      r_c         <= w_c;
      r_z         <= (w_res == '0);
      r_n         <= w_res[WIDTH-1];
      r_v         <= w_v;
      r_e         <= w_e;
    end else if (w_done) begin
      r_out_valid <= 1'b1;
      r_out       <= w_sh_res;
      r_c         <= w_sh_c;
      r_z         <= (w_sh_res == '0);
      r_n         <= w_sh_res[WIDTH-1];
      r_v         <= 1'b0;
      r_e         <= 1'b0;
    end else if (bus.Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.In_Ready  = w_in_ready;
  assign bus.Out_Valid = r_out_valid;
  assign bus.ALU_Out   = r_out;
  assign bus.Carry_Out = r_c;
  assign bus.Zero      = r_z;
  assign bus.Negative  = r_n;
  assign bus.Overflow  = r_v;
  assign bus.Error     = r_e;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's combinational ALU: same eight arithmetic/logic operations, generalised to `WIDTH` bits. Adds valid/ready handshakes on both sides, a registered result with status flags and illegal-opcode detection. Adds optional multi-cycle shift/rotate operations executed one bit per cycle. It sits between the register-file read stage and the write-back stage of the datapath.

## Interface
- `WIDTH`, 16: operand/result width in bits; must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, not overridden.
- `Clock`  in  1  single clock, all logic on rising edge.
- `Reset`  in  1  one clock; reset is synchronous and active-high.
- `In_Valid`  in  1  operand/opcode presented.
- `In_Ready`  out  1  block accepts on `In_Valid && In_Ready` at a rising edge.
- `A_In`, `B_In`  in  WIDTH  operands.
- `Carry_In`  in  1  carry for ADD/SUB.
- `Opcode`  in  4  0 ADD, 1 SUB, 2 NOTA, 3 ORAB, 4 ANDAB, 5 NOTAB, 6 EXOR, 7 EXNOR, 8 SHL, 9 SHR, 10 ASR, 11 ROL, 12–15 illegal.
- `Out_Valid`  out  1  result registers hold an unconsumed result.
- `Out_Ready`  in  1  consumer takes result on `Out_Valid && Out_Ready`.
- `ALU_Out`  out  WIDTH  result.
- `Carry_Out`, `Zero`, `Negative`, `Overflow`, `Error`  out  1 each  flags, registered with `ALU_Out`.

## Operation
- FSM states: IDLE, SHIFT.
- `In_Ready` = (state == IDLE) && (!Out_Valid || Out_Ready). Combinational, no dependence on `In_Valid`.
- Accept in IDLE, single-cycle op (0–7 or illegal): result and flags load into the output registers at the same edge, `Out_Valid`←1.
- Accept of a shift op (8–11): working reg←`A_In`, counter←`B_In[SHW-1:0]` (upper B bits ignored), state←SHIFT.
- SHIFT, counter ≠ 0: shift working reg one bit, capture the bit shifted out into carry, counter−1.
- SHIFT, counter == 0: transfer working reg and flags to the output, `Out_Valid`←1, state←IDLE.
- Shift ops: SHL fills 0; SHR fills 0; ASR replicates MSB; ROL wraps MSB→LSB. Shift carry = last bit shifted out, 0 when amount = 0.
- Arithmetic is computed at WIDTH+1 bits:
  - ADD: {C,R} = A + B + Carry_In.
  - SUB: {C,R} = A + ~B + Carry_In, so Carry_In=1 gives a true A−B and C=1 means no borrow.
  - Overflow (ADD/SUB only) = signed overflow: operand sign(s) agree and the result sign differs, using ~B for SUB.
- Logic ops: R = ~A, A|B, A&B, ~A&B, A^B, ~(A^B). Carry_Out = Overflow = 0.
- Zero = (R == 0), Negative = R[WIDTH-1], for every op.
- Illegal opcode: R = 0, Error = 1, Zero = 1, other flags 0. Error = 0 for all legal ops.
- Output drain: on `Out_Valid && Out_Ready` with no new load at that edge, `Out_Valid`←0. Output registers are held stable while `Out_Valid && !Out_Ready`.
- Simultaneous drain and load at one edge: the new result replaces the old, `Out_Valid` stays 1.

## Timing
- Reset: state IDLE, `Out_Valid`=0, `ALU_Out`=0, all flags 0. `In_Ready`=1 in the first cycle after reset.
- Reset mid-SHIFT aborts the operation; the partial result is discarded.
- Single-cycle op latency: 1 (accept at edge k → `Out_Valid` after k).
- Shift by N latency: N+1 edges after accept. `In_Ready`=0 for those cycles.
- Throughput: one single-cycle op per clock when `Out_Ready` is held at 1.
- A shift never needs to stall at transfer: acceptance guarantees the output registers are empty at the accept edge.

## Configuration
- `ALU_SEQ_SHIFT_EN` defined: SHIFT state, counter and working register present; opcodes 8–11 behave as above.
- Not defined: no SHIFT logic; opcodes 8–15 are illegal (Error=1, latency 1); `In_Ready` depends only on output occupancy.

## Test plan
- WIDTH=8: ADD A=0xFF, B=0x01, Carry_In=0 → next cycle ALU_Out=0x00, Carry_Out=1, Zero=1, Overflow=0.
- SUB A=0x80, B=0x01, Carry_In=1 → 0x7F, Carry_Out=1, Overflow=1, Negative=0. EXNOR 0xF0,0x3C → 0x33.
- Out_Ready=0 after one result: `In_Ready` drops, output holds 0x33 for 5 cycles. Raising Out_Ready while a new op is presented → drain and load at the same edge; back-to-back results.
- With the macro: ASR A=0x90, B=0x03 → `Out_Valid` 4 edges after accept, ALU_Out=0xF2, Carry_Out=0. ROL A=0x81, B=0x01 → 0x03, Carry_Out=1.
- Reset asserted 2 cycles into SHL by 7 → next cycle Out_Valid=0, ALU_Out=0, In_Ready=1; no result appears afterwards.
- Opcode 13 (and 9 without the macro) → ALU_Out=0x00, Error=1, Zero=1, latency 1.
